// File: rtl/framebuffer_clear_if.sv
// Avalon-MM burst write bus between framebuffer_clear and the f2h sdram1 port.
//   address     29  word address (64-bit units), valid on first beat of a burst
//   burstcount   8  beats in the burst, valid on first beat of a burst
//   waitrequest  1  slave stall
//   writedata   64  write data
//   byteenable   8  byte lanes
//   write        1  write strobe
interface framebuffer_clear_if;
   logic [28:0] address;
   logic [7:0]  burstcount;
   logic        waitrequest;
   logic [63:0] writedata;
   logic [7:0]  byteenable;
   logic        write;

   modport master (
      output address, burstcount, writedata, byteenable, write,
      input  waitrequest
   );

   modport slave (
      input  address, burstcount, writedata, byteenable, write,
      output waitrequest
   );
endinterface

// File: rtl/framebuffer_clear.sv
// Fills one framebuffer in HPS SDRAM with a solid colour using Avalon-MM
// burst writes; each 64-bit word carries two identical 32-bit XRGB pixels.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   start         1-cycle pulse, begins a clear (ignored while busy)
//   buffer        target framebuffer, sampled on start (0=FB0_BASE, 1=FB1_BASE)
//   colour        fill colour, sampled on start
//   abort         stop after the burst in flight
//   busy          high from the cycle after an accepted start until back in IDLE
//   done          1-cycle pulse when the whole frame has been written
//   av            Avalon-MM burst write master
module framebuffer_clear #(
   parameter logic [28:0] FB0_BASE  = 29'h0800000,
   parameter logic [28:0] FB1_BASE  = 29'h0A00000,
   parameter int unsigned FB_WORDS  = 153600,
   parameter int unsigned BURST_LEN = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                buffer,
   input  logic [31:0]         colour,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   framebuffer_clear_if.master av
);

   typedef enum logic [1:0] {IDLE, BURST, NEXT, FINISH} state_t;

   localparam logic [28:0] WORDS  = 29'(FB_WORDS);
   localparam logic [28:0] BLEN29 = 29'(BURST_LEN);
   localparam logic [7:0]  BLEN8  = 8'(BURST_LEN);

   state_t      state_q, state_d;
   logic [31:0] colour_q;
   logic [28:0] base_q;
   logic [28:0] offset_q;
   logic [28:0] remaining_q;
   logic [7:0]  beat_q;
   logic        abort_q;
   logic [7:0]  burst_len;
   logic        accept;
   logic        last_beat;

   // offset/remaining only change on the last beat, so address and
   // burstcount stay stable for the whole burst, including stalls.
   always_comb begin
      burst_len     = (remaining_q < BLEN29) ? remaining_q[7:0] : BLEN8;
      av.write      = (state_q == BURST);
      av.address    = base_q + offset_q;
      av.burstcount = burst_len;
      av.writedata  = {colour_q, colour_q};
      av.byteenable = av.write ? '1 : '0;
      accept        = av.write && !av.waitrequest;
      last_beat     = accept && (beat_q == burst_len - 8'd1);
      busy          = (state_q != IDLE);
      done          = (state_q == FINISH);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start) state_d = BURST;
         BURST:  if (last_beat) state_d = NEXT;
         NEXT: begin
            if (remaining_q == '0)
               state_d = FINISH;
            else if (abort_q || abort)
               state_d = IDLE;
            else
               state_d = BURST;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         colour_q    <= '0;
         base_q      <= '0;
         offset_q    <= '0;
         remaining_q <= '0;
         beat_q      <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               abort_q <= 1'b0;
               beat_q  <= '0;
               if (start) begin
                  colour_q    <= colour;
                  base_q      <= buffer ? FB1_BASE : FB0_BASE;
                  offset_q    <= '0;
                  remaining_q <= WORDS;
               end
            end
            BURST: begin
               if (abort) abort_q <= 1'b1;
               if (accept) begin
                  if (last_beat) begin
                     beat_q      <= '0;
                     offset_q    <= offset_q + {21'b0, burst_len};
                     remaining_q <= remaining_q - {21'b0, burst_len};
                  end else begin
                     beat_q <= beat_q + 8'd1;
                  end
               end
            end
            NEXT: if (abort) abort_q <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_framebuffer_clear.sv
module tb_framebuffer_clear;
   localparam logic [28:0] FB0 = 29'h0800000;
   localparam logic [28:0] FB1 = 29'h0A00000;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        start_a, buffer_a, abort_a, busy_a, done_a;
   logic [31:0] colour_a;
   logic        start_b, buffer_b, abort_b, busy_b, done_b;
   logic [31:0] colour_b;

   framebuffer_clear_if av_a ();
   framebuffer_clear_if av_b ();

   framebuffer_clear #(.FB0_BASE(FB0), .FB1_BASE(FB1), .FB_WORDS(40), .BURST_LEN(16)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .buffer(buffer_a), .colour(colour_a),
      .abort(abort_a), .busy(busy_a), .done(done_a), .av(av_a)
   );

   framebuffer_clear #(.FB0_BASE(FB0), .FB1_BASE(FB1), .FB_WORDS(1), .BURST_LEN(16)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .buffer(buffer_b), .colour(colour_b),
      .abort(abort_b), .busy(busy_b), .done(done_b), .av(av_b)
   );

   typedef struct {
      logic [28:0] addr;
      logic [7:0]  bc;
      bit          first;
      bit          gap_chk;
      logic [63:0] data;
   } beat_t;

   beat_t exp_q[$];
   int total = 0;
   int bad = 0;
   int done_exp = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Expected beats of a 40-word clear with 16-beat bursts: 16, 16, 8.
   task automatic push_clear(input logic buf_sel, input logic [31:0] col, input int unsigned max_beats);
      logic [28:0] base;
      int unsigned off;
      int unsigned n;
      base = buf_sel ? FB1 : FB0;
      off = 0;
      n = 0;
      while (off < 40) begin
         int unsigned bc;
         bc = (40 - off < 16) ? 40 - off : 16;
         for (int unsigned b = 0; b < bc; b++) begin
            beat_t e;
            e.addr    = base + 29'(off);
            e.bc      = 8'(bc);
            e.first   = (b == 0);
            e.gap_chk = (b == 0) && (off != 0);
            e.data    = {col, col};
            if (n < max_beats) exp_q.push_back(e);
            n++;
         end
         off += bc;
      end
   endtask

   // Monitor / scoreboard for dut_a
   int cyc = 0, beats = 0, done_cnt = 0, last_acc = 0, stall_cnt = 0;
   bit in_stall = 1'b0;
   logic [28:0] prev_addr;
   logic [7:0]  prev_bc;

   always @(negedge clock) begin
      cyc++;
      if (done_a) done_cnt++;
      if (av_a.write) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 64'(av_a.write), 64'd0);
         end else begin
            beat_t e;
            e = exp_q[0];
            check("writedata", av_a.writedata, e.data);
            check("byteenable", 64'(av_a.byteenable), 64'hFF);
            if (in_stall) begin
               check("stall_addr_hold", 64'(av_a.address), 64'(prev_addr));
               check("stall_bc_hold", 64'(av_a.burstcount), 64'(prev_bc));
            end
            if (av_a.waitrequest) begin
               in_stall  = 1'b1;
               stall_cnt++;
               prev_addr = av_a.address;
               prev_bc   = av_a.burstcount;
            end else begin
               if (e.first) begin
                  check("address", 64'(av_a.address), 64'(e.addr));
                  check("burstcount", 64'(av_a.burstcount), 64'(e.bc));
               end
               if (e.gap_chk)
                  check("burst_gap", 64'(cyc - last_acc), 64'd2);
               else if (!e.first)
                  check("beat_gap", 64'(cyc - last_acc), 64'(1 + stall_cnt));
               void'(exp_q.pop_front());
               beats++;
               last_acc  = cyc;
               stall_cnt = 0;
               in_stall  = 1'b0;
            end
         end
      end
   end

   task automatic kick(input logic b, input logic [31:0] c);
      buffer_a = b;
      colour_a = c;
      start_a  = 1'b1;
      @(posedge clock); #1;
      start_a  = 1'b0;
      buffer_a = ~b;
      colour_a = ~c;
      check("start_latency_write", 64'(av_a.write), 64'd1);
      check("busy_after_start", 64'(busy_a), 64'd1);
   endtask

   task automatic wait_beats(input int target);
      int n;
      n = 0;
      while (beats < target && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      check("beat_wait", 64'(beats >= target), 64'd1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy_a && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      check({name, "_idle"}, 64'(busy_a), 64'd0);
      @(posedge clock); #1;
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      check({name, "_done_count"}, 64'(done_cnt), 64'(done_exp));
   endtask

   initial begin
      int base;
      int n;
      int b_beats, b_done, b_done_cyc;
      reset = 1'b1;
      start_a = 1'b0; buffer_a = 1'b0; colour_a = '0; abort_a = 1'b0;
      start_b = 1'b0; buffer_b = 1'b0; colour_b = '0; abort_b = 1'b0;
      av_a.waitrequest = 1'b0;
      av_b.waitrequest = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_write", 64'(av_a.write), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_address", 64'(av_a.address), 64'd0);
      check("rst_burstcount", 64'(av_a.burstcount), 64'd0);
      check("rst_writedata", av_a.writedata, 64'd0);
      check("rst_byteenable", 64'(av_a.byteenable), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Plain clear of FB0, with a start during busy that must be ignored,
      // then start held across the done cycle and the one after it.
      push_clear(1'b0, 32'h00112233, 40);
      done_exp++;
      base = beats;
      kick(1'b0, 32'h00112233);
      wait_beats(base + 20);
      buffer_a = 1'b1; colour_a = 32'hDEADBEEF; start_a = 1'b1;
      @(posedge clock); #1;
      start_a = 1'b0;
      n = 0;
      while (!done_a && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      check("done_seen", 64'(done_a), 64'd1);
      check("t1_beats", 64'(beats - base), 64'd40);
      buffer_a = 1'b0; colour_a = 32'hA5A55A5A; start_a = 1'b1;
      push_clear(1'b0, 32'hA5A55A5A, 40);
      done_exp++;
      @(posedge clock); #1;
      check("start_in_done_ignored", 64'(busy_a), 64'd0);
      @(posedge clock); #1;
      start_a = 1'b0;
      check("start_after_done_write", 64'(av_a.write), 64'd1);
      wait_idle("t1");

      // FB1 clear with beat 5 stalled for three cycles.
      push_clear(1'b1, 32'hCAFEF00D, 40);
      done_exp++;
      base = beats;
      kick(1'b1, 32'hCAFEF00D);
      wait_beats(base + 4);
      av_a.waitrequest = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      av_a.waitrequest = 1'b0;
      wait_idle("t2");
      check("t2_beats", 64'(beats - base), 64'd40);

      // Abort during beat 3: first burst completes, nothing more, no done.
      push_clear(1'b0, 32'h01020304, 16);
      base = beats;
      kick(1'b0, 32'h01020304);
      wait_beats(base + 2);
      abort_a = 1'b1;
      @(posedge clock); #1;
      abort_a = 1'b0;
      wait_idle("t3");
      repeat (5) @(posedge clock);
      #1;
      check("t3_beats", 64'(beats - base), 64'd16);

      // Reset during beat 7, then a fresh clear from offset 0.
      push_clear(1'b1, 32'h55667788, 40);
      base = beats;
      kick(1'b1, 32'h55667788);
      wait_beats(base + 6);
      reset = 1'b1;
      #1;
      check("rst_mid_write", 64'(av_a.write), 64'd0);
      check("rst_mid_busy", 64'(busy_a), 64'd0);
      check("rst_mid_left", 64'(exp_q.size()), 64'd34);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      push_clear(1'b0, 32'h0F0F0F0F, 40);
      done_exp++;
      base = beats;
      kick(1'b0, 32'h0F0F0F0F);
      wait_idle("t4");
      check("t4_beats", 64'(beats - base), 64'd40);

      // Single-word frame: start is cycle 0, beat at 1, done at 3.
      b_beats = 0; b_done = 0; b_done_cyc = -1;
      buffer_b = 1'b0; colour_b = 32'h00FF00FF; start_b = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (av_b.write && !av_b.waitrequest) begin
            b_beats++;
            check("b_beat_cycle", 64'(k), 64'd1);
            check("b_burstcount", 64'(av_b.burstcount), 64'd1);
            check("b_address", 64'(av_b.address), 64'(FB0));
            check("b_writedata", av_b.writedata, 64'h00FF00FF00FF00FF);
         end
         if (done_b) begin
            b_done++;
            b_done_cyc = k;
         end
         @(posedge clock); #1;
         start_b = 1'b0;
      end
      check("b_beats", 64'(b_beats), 64'd1);
      check("b_done_pulses", 64'(b_done), 64'd1);
      check("b_done_cycle", 64'(b_done_cyc), 64'd3);
      check("b_idle", 64'(busy_b), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
